// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register offsets and sizing shared by the interrupt controller.
package irq_ctrl_pkg;
  localparam int IRQ_MAX = 8;
  localparam int IRQ_VEC_W = 3;
  typedef enum logic [1:0] {
    IRQ_OFF_PENDING = 2'd0,
    IRQ_OFF_ENABLE  = 2'd1,
    IRQ_OFF_EDGE    = 2'd2,
    IRQ_OFF_STATUS  = 2'd3
  } irq_off_e;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational priority encoder, lowest set index wins.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int N = IRQ_MAX
) (
  input  logic [N-1:0]         req_i,
  output logic                 any_o,
  output logic [IRQ_VEC_W-1:0] idx_o
);
  always_comb begin
    any_o = |req_i;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req_i[i]) idx_o = IRQ_VEC_W'(i);
  end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: N-channel interrupt controller with pending/enable/edge registers,
// fixed-priority request/vector to the CPU and per-channel clear pulses.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          N_IRQ     = 8,
  parameter logic [15:0] BASE_ADDR = 16'h1100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          address,
  input  logic [7:0]           din,
  input  logic                 w_en,
  input  logic                 r_en,
  output logic [7:0]           dout,
  input  logic [N_IRQ-1:0]     irq_src,
  output logic [N_IRQ-1:0]     irq_src_clr,
  output logic                 irq_req,
  output logic [IRQ_VEC_W-1:0] irq_vec,
  input  logic                 irq_ack
);
  logic [N_IRQ-1:0] pend_q, pend_d, en_q, en_d, edge_q, edge_d, prev_q, clr_q, clr_d;
  logic [N_IRQ-1:0] wclr, aclr, set;
  logic [7:0] dout_q, dout_d;
  logic req_q, req_d;
  logic [IRQ_VEC_W-1:0] vec_q, vec_d;
  logic sel, wr, rd;
  logic [1:0] off;

  irq_prio_enc #(.N(N_IRQ)) u_enc (
    .req_i(pend_q & en_q),
    .any_o(req_d),
    .idx_o(vec_d)
  );

  always_comb begin
    sel = address[15:2] == BASE_ADDR[15:2];
    off = address[1:0];
    wr = sel & w_en;
    rd = sel & r_en;
    wclr = (wr && off == IRQ_OFF_PENDING) ? din[N_IRQ-1:0] : '0;
    aclr = (irq_ack && req_q) ? N_IRQ'(1) << vec_q : '0;
    clr_d = wclr | aclr;
    // level channels set on the source alone, edge channels need a 0->1 step
    set = irq_src & (~edge_q | ~prev_q);
    pend_d = (pend_q & ~clr_d) | set;
    en_d = (wr && off == IRQ_OFF_ENABLE) ? din[N_IRQ-1:0] : en_q;
    edge_d = (wr && off == IRQ_OFF_EDGE) ? din[N_IRQ-1:0] : edge_q;
    dout_d = !rd ? dout_q :
             off == IRQ_OFF_PENDING ? 8'(pend_q) :
             off == IRQ_OFF_ENABLE  ? 8'(en_q) :
             off == IRQ_OFF_EDGE    ? 8'(edge_q) : {req_q, 4'b0, vec_q};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      en_q   <= '0;
      edge_q <= '0;
      prev_q <= '0;
      clr_q  <= '0;
      dout_q <= '0;
      req_q  <= 1'b0;
      vec_q  <= '0;
    end else begin
      pend_q <= pend_d;
      en_q   <= en_d;
      edge_q <= edge_d;
      prev_q <= irq_src;
      clr_q  <= clr_d;
      dout_q <= dout_d;
      req_q  <= req_d;
      vec_q  <= vec_d;
    end
  end

  assign dout = dout_q;
  assign irq_src_clr = clr_q;
  assign irq_req = req_q;
  assign irq_vec = vec_q;
endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Parametrised interrupt controller on the data-memory/IO bus, between peripheral interrupt flags (video blanking, timer top/match and future sources) and the CPU. It generalises the current fixed four-line flag/clear wiring to `N_IRQ` channels. Each channel has a pending latch, an enable mask and per-channel edge/level mode. A fixed-priority encoder drives a single request line plus a vector to the CPU. When a request is serviced, the controller issues a one-cycle clear pulse back to the originating peripheral.

## Interface
- `N_IRQ`, 8: number of interrupt channels, legal range 1..8.
- `BASE_ADDR`, 16'h1100: base of the 4-byte register window; must be 4-byte aligned.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `address`  in  16  bus address.
- `din`  in  8  bus write data.
- `w_en`  in  1  bus write strobe, one cycle.
- `r_en`  in  1  bus read strobe, one cycle.
- `dout`  out  8  registered read data.
- `irq_src`  in  N_IRQ  peripheral flags, synchronous to `clk`.
- `irq_src_clr`  out  N_IRQ  one-cycle clear pulse per channel to its peripheral.
- `irq_req`  out  1  registered interrupt request to the CPU.
- `irq_vec`  out  3  registered index of the highest-priority active channel.
- `irq_ack`  in  1  CPU acknowledge pulse for the current `irq_vec`.

## Operation
- Decode: a cycle is selected when `address[15:2] == BASE_ADDR[15:2]`. `off = address[1:0]`.
- Register map. Bits at index `N_IRQ` and above read 0 and ignore writes.
  - off 0 PENDING: read; write-1-to-clear.
  - off 1 ENABLE: read/write.
  - off 2 EDGE: read/write. 1 = rising-edge mode, 0 = level mode.
  - off 3 STATUS: read-only. Bit7 = `irq_req`, bits[2:0] = `irq_vec`, others 0.
- Edge mode: `prev[i]` holds the last sample of `irq_src[i]`. `pending[i]` sets on `irq_src[i] & ~prev[i]`.
- Level mode: `pending[i]` sets every cycle that `irq_src[i]` is 1.
- Clear sources for `pending[i]`:
  - a PENDING write with `din[i]=1`;
  - `irq_ack` while `irq_vec==i` and `irq_req==1`.
  - Either source also drives `irq_src_clr[i]=1` in the next cycle.
- Simultaneous set and clear on one channel in the same cycle: set wins, so no event is lost. The clear pulse is still emitted.
- Active vector = `pending & ENABLE`. Priority is fixed, lowest index highest. `irq_req = |active`. `irq_vec` = encoded index of the lowest set bit, or 0 when none is set.
- Masking never clears pending. Re-enabling a channel with pending set raises `irq_req`.
- `irq_ack` while `irq_req==0` is ignored, with no clear pulse.
- Writes and reads to an unselected address: no effect; `dout` holds its value.

## Timing
- Reset: `pending`, ENABLE, EDGE and `prev` are 0. `dout=0`, `irq_src_clr=0`, `irq_req=0`, `irq_vec=0`. Reset applies immediately, mid-transaction included, and drops any in-flight clear pulse.
- Source edge sampled at cycle k: `pending` is set at k+1, `irq_req`/`irq_vec` are valid at k+2.
- Read: `dout` is valid the cycle after the `r_en` cycle, matching the synchronous data RAM. A read of PENDING returns the pre-update value. A read and a write in the same cycle: the read returns the old value.
- Write: the register updates at the edge ending the `w_en` cycle. An ENABLE write reaches `irq_req` one cycle later.
- Ack at cycle a: `pending` clears at a+1, `irq_src_clr` pulses during a+1, and `irq_req`/`irq_vec` reflect the next channel at a+2.
- Level-mode source still high after a clear: pending re-sets one cycle later. Software must clear the peripheral condition.

## Structure
- Package `irq_ctrl_pkg` holds:
  - register offsets `IRQ_OFF_PENDING`, `IRQ_OFF_ENABLE`, `IRQ_OFF_EDGE`, `IRQ_OFF_STATUS`;
  - `IRQ_MAX=8`;
  - `IRQ_VEC_W=3`.
- Sub-module `irq_prio_enc`: combinational N-input lowest-index-first encoder producing `any` and `idx[2:0]`. Its outputs are registered in `irq_ctrl`.

## Test plan
- Reset, then read all four offsets: each returns 8'h00. `irq_req=0`, `irq_src_clr=0`.
- EDGE=8'hFF, ENABLE=8'h04. Pulse `irq_src[2]` high for 5 cycles, rising at cycle k. Required: PENDING=8'h04, a single set, `irq_req=1` at k+2, `irq_vec=2`. After `irq_ack`: `irq_src_clr=8'h04` for exactly one cycle and `irq_req=0`.
- ENABLE=8'h0A, edges on `irq_src[1]` and `irq_src[3]` in the same cycle. Required: `irq_vec=1` first; after ack, `irq_vec=3`; after a second ack, `irq_req=0`.
- Level mode with `irq_src[0]` held high. Write PENDING=8'h01. Required: `irq_src_clr[0]` pulses, and PENDING reads 8'h01 again one cycle later.
- ENABLE=0 with an edge on `irq_src[5]`. Required: PENDING=8'h20, `irq_req=0`. Then write ENABLE=8'h20: `irq_req=1`, `irq_vec=5` one cycle after the write.
- Assert `reset` while `irq_req=1` and a clear pulse is due. Required: all outputs are 0 in the same cycle, and no `irq_src_clr` pulse appears after reset release.
